// File: rtl/timer_pkg.sv
// Shared timing constants for the countdown timer.
// All rates are derived from one clock constant: TickDivDefault CLK cycles make 1 ms.
package timer_pkg;

  localparam logic [15:0] TickDivDefault       = 16'd2440;
  localparam logic [7:0]  DebounceMsDefault    = 8'd20;
  localparam logic [15:0] OneSecMsDefault      = 16'd1000;
  localparam logic [15:0] RepeatDelayMsDefault = 16'd500;
  localparam logic [15:0] RepeatRateMsDefault  = 16'd100;

  // The countdown core's HALF_KHZ strobe divides the same clock: one period every 2 ms.
  localparam logic [15:0] HalfKhzDiv = 16'(2 * TickDivDefault);

  // Bit positions of the four keys in the front-end's press vector.
  typedef enum logic [1:0] {
    KeyStart = 2'd0,
    KeyStop  = 2'd1,
    KeySec   = 2'd2,
    KeyMin   = 2'd3
  } key_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, tick-based debounce, press event and
// optional auto-repeat while held.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   tick_i  1 ms strobe, one cycle wide
//   key_i   raw button level, asynchronous
//   press_o combinational press/repeat event, one cycle wide (registered by the parent)
module key_debounce
  import timer_pkg::*;
#(
  parameter bit          REPEAT_EN       = 1'b0,
  parameter logic [7:0]  DEBOUNCE_MS     = DebounceMsDefault,
  parameter logic [15:0] REPEAT_DELAY_MS = RepeatDelayMsDefault,
  parameter logic [15:0] REPEAT_RATE_MS  = RepeatRateMsDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic key_i,
  output logic press_o
);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rise;
  logic       repeat_evt;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    if (tick_i) begin
      if (sync2_q == stable_q) begin
        // Any agreement with the stable level restarts the count.
        cnt_d = '0;
      end else if (cnt_q + 8'd1 == DEBOUNCE_MS) begin
        cnt_d    = '0;
        stable_d = ~stable_q;
        rise     = ~stable_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  if (REPEAT_EN) begin : g_repeat
    logic [15:0] hold_q, hold_d;
    logic        rep;

    always_comb begin
      hold_d = hold_q;
      rep    = 1'b0;
      if (!stable_d) begin
        hold_d = '0;
      end else if (tick_i && stable_q) begin
        // Only ticks after the press count as hold time.
        if (hold_q + 16'd1 == REPEAT_DELAY_MS) begin
          hold_d = REPEAT_DELAY_MS - REPEAT_RATE_MS;
          rep    = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end

    assign repeat_evt = rep;
  end else begin : g_no_repeat
    assign repeat_evt = 1'b0;
  end

  assign press_o = rise | repeat_evt;

endmodule

// File: rtl/timer_key_frontend.sv
// Input front-end for the countdown timer: debounces START, STOP, SEC and MIN keys into
// single-cycle pulses (with auto-repeat on SEC/MIN) and generates the 1 Hz count pulse.
// Ports:
//   CLK, RES            clock and synchronous active-high reset
//   KEY_*               raw active-high button levels, asynchronous to CLK
//   DEBOUNCED_START/STOP, COUNT_UP_SEC/MIN_PULSE, ONE_SEC_PULSE  registered 1-cycle pulses
module timer_key_frontend
  import timer_pkg::*;
#(
  parameter logic [15:0] TICK_DIV        = TickDivDefault,
  parameter logic [7:0]  DEBOUNCE_MS     = DebounceMsDefault,
  parameter logic [15:0] ONE_SEC_MS      = OneSecMsDefault,
  parameter logic [15:0] REPEAT_DELAY_MS = RepeatDelayMsDefault,
  parameter logic [15:0] REPEAT_RATE_MS  = RepeatRateMsDefault
) (
  input  logic CLK,
  input  logic RES,
  input  logic KEY_START,
  input  logic KEY_STOP,
  input  logic KEY_SEC,
  input  logic KEY_MIN,
  output logic DEBOUNCED_START,
  output logic DEBOUNCED_STOP,
  output logic COUNT_UP_SEC_PULSE,
  output logic COUNT_UP_MIN_PULSE,
  output logic ONE_SEC_PULSE
);

  logic        tick;
  logic [15:0] presc_q, presc_d;
  logic [15:0] sec_q, sec_d;
  logic        sec_wrap;
  logic [3:0]  press;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        sec_pulse_q, sec_pulse_d;
  logic        min_pulse_q, min_pulse_d;
  logic        one_sec_q, one_sec_d;

  assign tick = (presc_q == TICK_DIV - 16'd1);

  key_debounce #(
    .REPEAT_EN(1'b0), .DEBOUNCE_MS(DEBOUNCE_MS),
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS), .REPEAT_RATE_MS(REPEAT_RATE_MS)
  ) u_key_start (
    .clk_i(CLK), .rst_i(RES), .tick_i(tick), .key_i(KEY_START), .press_o(press[KeyStart])
  );

  key_debounce #(
    .REPEAT_EN(1'b0), .DEBOUNCE_MS(DEBOUNCE_MS),
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS), .REPEAT_RATE_MS(REPEAT_RATE_MS)
  ) u_key_stop (
    .clk_i(CLK), .rst_i(RES), .tick_i(tick), .key_i(KEY_STOP), .press_o(press[KeyStop])
  );

  key_debounce #(
    .REPEAT_EN(1'b1), .DEBOUNCE_MS(DEBOUNCE_MS),
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS), .REPEAT_RATE_MS(REPEAT_RATE_MS)
  ) u_key_sec (
    .clk_i(CLK), .rst_i(RES), .tick_i(tick), .key_i(KEY_SEC), .press_o(press[KeySec])
  );

  key_debounce #(
    .REPEAT_EN(1'b1), .DEBOUNCE_MS(DEBOUNCE_MS),
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS), .REPEAT_RATE_MS(REPEAT_RATE_MS)
  ) u_key_min (
    .clk_i(CLK), .rst_i(RES), .tick_i(tick), .key_i(KEY_MIN), .press_o(press[KeyMin])
  );

  always_comb begin
    presc_d  = presc_q + 16'd1;
    sec_d    = sec_q;
    sec_wrap = 1'b0;
    if (tick) begin
      presc_d = '0;
      if (sec_q == ONE_SEC_MS - 16'd1) begin
        sec_d    = '0;
        sec_wrap = 1'b1;
      end else begin
        sec_d = sec_q + 16'd1;
      end
    end
    // Restart the second from the registered START pulse so the first second is full.
    if (start_q) begin
      presc_d  = '0;
      sec_d    = '0;
      sec_wrap = 1'b0;
    end
    // STOP wins a same-cycle collision; the START event is dropped.
    start_d     = press[KeyStart] & ~press[KeyStop];
    stop_d      = press[KeyStop];
    sec_pulse_d = press[KeySec];
    min_pulse_d = press[KeyMin];
    one_sec_d   = sec_wrap;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      presc_q     <= '0;
      sec_q       <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      one_sec_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      sec_pulse_q <= sec_pulse_d;
      min_pulse_q <= min_pulse_d;
      one_sec_q   <= one_sec_d;
    end
  end

  assign DEBOUNCED_START    = start_q;
  assign DEBOUNCED_STOP     = stop_q;
  assign COUNT_UP_SEC_PULSE = sec_pulse_q;
  assign COUNT_UP_MIN_PULSE = min_pulse_q;
  assign ONE_SEC_PULSE      = one_sec_q;

endmodule

// File: tb/tb_timer_key_frontend.sv
// Bench for timer_key_frontend with small timing constants. A cycle-level reference model
// built from the key timing rules predicts every output on every cycle; directed scenarios
// add latency, count and spacing checks.
module tb_timer_key_frontend;

  localparam int TD = 4;   // cycles per tick
  localparam int DB = 3;   // debounce ticks
  localparam int OS = 10;  // ticks per second
  localparam int RD = 8;   // repeat delay (ticks)
  localparam int RR = 2;   // repeat rate (ticks)

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] key;  // 0 start, 1 stop, 2 sec, 3 min
  logic       o_start, o_stop, o_sec, o_min, o_one;

  timer_key_frontend #(
    .TICK_DIV(16'd4), .DEBOUNCE_MS(8'd3), .ONE_SEC_MS(16'd10),
    .REPEAT_DELAY_MS(16'd8), .REPEAT_RATE_MS(16'd2)
  ) dut (
    .CLK(clk), .RES(res),
    .KEY_START(key[0]), .KEY_STOP(key[1]), .KEY_SEC(key[2]), .KEY_MIN(key[3]),
    .DEBOUNCED_START(o_start), .DEBOUNCED_STOP(o_stop),
    .COUNT_UP_SEC_PULSE(o_sec), .COUNT_UP_MIN_PULSE(o_min), .ONE_SEC_PULSE(o_one)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state, describing the cycle currently visible.
  int         cyc = 0;
  int         origin = 0;     // first cycle of the current tick phase
  int         nticks = 0;     // ticks since phase origin
  bit         stable [4];
  int         since_flip [4]; // ticks since last stable change or reset
  bit         samp [4][DB];   // most recent tick samples of the synced level
  int         held [4];       // ticks held since press
  bit         d1 [4];
  bit         d2 [4];
  logic [4:0] exp_q = '0;     // {one, min, sec, stop, start}

  int pulse_cnt [5];
  int last_pulse [5];
  int sec_at [$];

  task automatic model_edge();
    bit       tick;
    bit [3:0] ev;
    bit       one;
    bit       allx;
    tick = ((cyc - origin) % TD) == TD - 1;
    if (res) begin
      for (int k = 0; k < 4; k++) begin
        stable[k] = 0; since_flip[k] = 0; held[k] = 0; d1[k] = 0; d2[k] = 0;
      end
      origin = cyc + 1;
      nticks = 0;
      exp_q  = '0;
    end else begin
      ev = '0;
      for (int k = 0; k < 4; k++) begin
        if (tick) begin
          for (int j = DB - 1; j > 0; j--) samp[k][j] = samp[k][j-1];
          samp[k][0] = d2[k];
          since_flip[k]++;
          allx = 1;
          for (int j = 0; j < DB; j++) if (samp[k][j] == stable[k]) allx = 0;
          if (since_flip[k] >= DB && allx) begin
            stable[k]     = !stable[k];
            since_flip[k] = 0;
            held[k]       = 0;
            if (stable[k]) ev[k] = 1;
          end else if (stable[k] && k >= 2) begin
            held[k]++;
            if (held[k] >= RD && (held[k] - RD) % RR == 0) ev[k] = 1;
          end
        end
      end
      one = 0;
      if (exp_q[0]) begin
        origin = cyc + 1;
        nticks = 0;
      end else if (tick) begin
        nticks++;
        one = (nticks % OS) == 0;
      end
      for (int k = 0; k < 4; k++) begin
        d2[k] = d1[k];
        d1[k] = key[k];
      end
      exp_q = {one, ev[3], ev[2], ev[1], ev[0] & ~ev[1]};
    end
    cyc++;
  endtask

  task automatic step(input logic r, input logic [3:0] k);
    logic [4:0] obs;
    res = r;
    key = k;
    @(posedge clk);
    model_edge();
    #1;
    obs = {o_one, o_min, o_sec, o_stop, o_start};
    tests++;
    assert (obs === exp_q) else begin
      fails++;
      $error("FAIL outputs cyc=%0d got=%b want=%b", cyc, obs, exp_q);
    end
    for (int i = 0; i < 5; i++) begin
      if (obs[i] === 1'b1) begin
        pulse_cnt[i]++;
        last_pulse[i] = cyc;
      end
    end
    if (obs[2] === 1'b1) sec_at.push_back(cyc);
  endtask

  task automatic steps(input int n, input logic [3:0] k);
    for (int i = 0; i < n; i++) step(1'b0, k);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    assert (got == want) else begin
      fails++;
      $error("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) begin
      pulse_cnt[i]  = 0;
      last_pulse[i] = -1;
    end
    sec_at.delete();
  endtask

  initial begin
    int t0, lat, got, p1;
    logic [3:0] rk;
    res = 1'b1;
    key = '0;
    clear_counts();

    // Reset, then free-running second pulse.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000);
    t0 = cyc;
    steps(45, 4'b0000);
    check("first_one_sec_cycle", last_pulse[4] - t0, 40);
    steps(40, 4'b0000);
    check("second_one_sec_cycle", last_pulse[4] - t0, 80);
    check("one_sec_count", pulse_cnt[4], 2);

    // Clean press, release, re-press.
    clear_counts();
    t0 = cyc;
    steps(30, 4'b0001);
    lat = last_pulse[0] - t0;
    check("start_latency_in_range", int'(lat >= 11 && lat <= 14), 1);
    check("start_single_pulse", pulse_cnt[0], 1);
    steps(30, 4'b0000);
    check("no_pulse_on_release", pulse_cnt[0], 1);
    steps(30, 4'b0001);
    check("start_second_press", pulse_cnt[0], 2);
    steps(30, 4'b0000);

    // Bouncing STOP key.
    clear_counts();
    for (int i = 0; i < 40; i++) step(1'b0, ((i / 6) % 2 == 0) ? 4'b0010 : 4'b0000);
    steps(30, 4'b0000);
    check("bounce_no_stop", pulse_cnt[1], 0);

    // Auto-repeat on SEC, none on START.
    clear_counts();
    steps(80, 4'b0100);
    steps(30, 4'b0000);
    check("sec_pulses_seen", int'(sec_at.size() >= 3), 1);
    if (sec_at.size() >= 3) begin
      check("first_repeat_gap", sec_at[1] - sec_at[0], 32);
      check("repeat_period", sec_at[2] - sec_at[1], 8);
    end
    steps(80, 4'b0001);
    check("start_no_repeat", pulse_cnt[0], 1);
    steps(30, 4'b0000);

    // Simultaneous keys.
    clear_counts();
    steps(30, 4'b0011);
    check("simul_stop_only", pulse_cnt[1], 1);
    check("simul_start_dropped", pulse_cnt[0], 0);
    steps(30, 4'b0000);
    steps(20, 4'b1100);
    check("sec_min_same_cycle", last_pulse[2] - last_pulse[3], 0);
    check("sec_min_both", pulse_cnt[2] + pulse_cnt[3], 2);
    steps(30, 4'b0000);

    // START restarts the second phase.
    clear_counts();
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      step(1'b0, 4'b0000);
      if (last_pulse[4] == cyc) got = 1;
    end
    check("phase_sync_seen", got, 1);
    steps(13, 4'b0000);
    steps(20, 4'b0001);
    p1 = last_pulse[0];
    steps(40, 4'b0000);
    check("one_sec_after_start", last_pulse[4] - p1, 41);

    // Reset while MIN is held: re-debounce gives a fresh press.
    clear_counts();
    steps(20, 4'b1000);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1000);
    steps(25, 4'b1000);
    check("min_press_after_reset", pulse_cnt[3], 2);
    steps(30, 4'b0000);

    // Random key activity, with occasional resets.
    for (int s = 0; s < 60; s++) begin
      rk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, rk);
      end
      steps(int'($urandom_range(1, 40)), rk);
    end
    steps(40, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
